// File: rtl/diag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | diag_pkg : state encoding and pass geometry for diag_loop_sequencer      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package diag_pkg;

  localparam int DIAG_N          = 8;
  localparam int DIAG_ADDR_WIDTH = $clog2(DIAG_N);
  localparam int DIAG_CNT_WIDTH  = $clog2(DIAG_N * DIAG_N + 1);

  function automatic int feed_len(input int n);
    return n + 1;
  endfunction

  function automatic int sweep_len(input int n);
    return n;
  endfunction

  localparam int FEED_LEN  = feed_len(DIAG_N);
  localparam int SWEEP_LEN = sweep_len(DIAG_N);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FEED    = 3'd1,
    ST_SWEEP   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } diag_state_t;

endpackage
`default_nettype wire

// File: rtl/diag_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | diag_popcount : combinational set-bit count of a WIDTH-bit vector        |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module diag_popcount
  import diag_pkg::*;
#(
  parameter int WIDTH     = DIAG_N,
  parameter int OUT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]     vec,
  output logic [OUT_WIDTH-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_WIDTH'(vec[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/diag_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | diag_loop_sequencer : one diagnostic pass over the loop chain            |
// | (feed fault rows, recirculate, capture summary)          rev 1.0         |
// +--------------------------------------------------------------------------+
module diag_loop_sequencer
  import diag_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = DIAG_N,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
  parameter int CNT_WIDTH     = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     fault_rd_en,
  output logic [ADDR_WIDTH-1:0]    fault_rd_addr,
  input  logic [SYSTOLIC_SIZE-1:0] fault_rd_data,
  output logic                     chain_start_en,
  output logic [SYSTOLIC_SIZE-1:0] chain_col_inputs,
  input  logic [SYSTOLIC_SIZE-1:0] chain_single_pe,
  input  logic [SYSTOLIC_SIZE-1:0] chain_col_fault,
  input  logic [SYSTOLIC_SIZE-1:0] chain_row_fault,
  output logic                     res_valid,
  output logic [ADDR_WIDTH-1:0]    res_row,
  output logic [SYSTOLIC_SIZE-1:0] res_pe_mask,
  output logic [SYSTOLIC_SIZE-1:0] sum_col_fault,
  output logic [SYSTOLIC_SIZE-1:0] sum_row_fault,
  output logic [CNT_WIDTH-1:0]     pe_fault_count
);

  localparam int N  = SYSTOLIC_SIZE;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(N + 1);

  localparam logic [CW-1:0] FEED_LAST  = CW'(feed_len(N) - 1);
  localparam logic [CW-1:0] SWEEP_LAST = CW'(sweep_len(N) - 1);
  localparam logic [CW-1:0] RD_LAST    = CW'(N - 1);

  diag_state_t             state_q,     state_d;
  logic [CW-1:0]           cnt_q,       cnt_d;
  logic                    busy_q,      busy_d;
  logic                    done_q,      done_d;
  logic                    rd_en_q,     rd_en_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q,   rd_addr_d;
  logic                    start_en_q,  start_en_d;
  logic                    feed_sel_q,  feed_sel_d;
  logic                    res_valid_q, res_valid_d;
  logic [ADDR_WIDTH-1:0]   res_row_q,   res_row_d;
  logic [N-1:0]            res_mask_q,  res_mask_d;
  logic [N-1:0]            sum_col_q,   sum_col_d;
  logic [N-1:0]            sum_row_q,   sum_row_d;
  logic [CNT_WIDTH-1:0]    count_q,     count_d;
  logic [PW-1:0]           pop;

  diag_popcount #(
    .WIDTH     (N),
    .OUT_WIDTH (PW)
  ) u_popcount (
    .vec   (chain_single_pe),
    .count (pop)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    start_en_d = 1'b0;
    feed_sel_d = 1'b0;
    sum_col_d  = sum_col_q;
    sum_row_d  = sum_row_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (start) begin
          state_d = ST_FEED;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
        end
      end
      ST_FEED: begin
        start_en_d = 1'b1;
        if (cnt_q == FEED_LAST) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end else begin
          // Read data lands one cycle after the strobe, so feeding lags reads by one.
          feed_sel_d = 1'b1;
          rd_en_d    = (cnt_q < RD_LAST);
          if (rd_en_d) begin
            rd_addr_d = cnt_d[ADDR_WIDTH-1:0];
          end
        end
      end
      ST_SWEEP: begin
        start_en_d = 1'b1;
        if (cnt_q == SWEEP_LAST) begin
          state_d    = ST_CAPTURE;
          cnt_d      = '0;
          start_en_d = 1'b0;
        end
      end
      ST_CAPTURE: begin
        state_d   = ST_DONE;
        cnt_d     = '0;
        done_d    = 1'b1;
        sum_col_d = chain_col_fault;
        sum_row_d = chain_row_fault;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      rd_en_d    = 1'b0;
      rd_addr_d  = '0;
      start_en_d = 1'b0;
      feed_sel_d = 1'b0;
      sum_col_d  = sum_col_q;
      sum_row_d  = sum_row_q;
    end
  end

  // A row fed this cycle is reported next cycle, even if the pass is being aborted.
  always_comb begin
    res_valid_d = feed_sel_q;
    res_row_d   = res_row_q;
    res_mask_d  = res_mask_q;
    count_d     = count_q;
    if ((state_q == ST_IDLE) && start) begin
      count_d = '0;
    end else if (feed_sel_q) begin
      res_row_d  = ADDR_WIDTH'(cnt_q - CW'(1));
      res_mask_d = chain_single_pe;
      count_d    = count_q + CNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      start_en_q  <= 1'b0;
      feed_sel_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_row_q   <= '0;
      res_mask_q  <= '0;
      sum_col_q   <= '0;
      sum_row_q   <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      start_en_q  <= start_en_d;
      feed_sel_q  <= feed_sel_d;
      res_valid_q <= res_valid_d;
      res_row_q   <= res_row_d;
      res_mask_q  <= res_mask_d;
      sum_col_q   <= sum_col_d;
      sum_row_q   <= sum_row_d;
      count_q     <= count_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign fault_rd_en      = rd_en_q;
  assign fault_rd_addr    = rd_addr_q;
  assign chain_start_en   = start_en_q;
  assign chain_col_inputs = feed_sel_q ? fault_rd_data : '0;
  assign res_valid        = res_valid_q;
  assign res_row          = res_row_q;
  assign res_pe_mask      = res_mask_q;
  assign sum_col_fault    = sum_col_q;
  assign sum_row_fault    = sum_row_q;
  assign pe_fault_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_diag_loop_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_diag_loop_sequencer : sticky loop-chain stand-in, fault memory and a  |
// | pass-level reference model predicting every strobe after start           |
// | rev 1.1                                                                  |
// +--------------------------------------------------------------------------+
module tb_diag_loop_sequencer;

    localparam int N     = 8;
    localparam int AW    = $clog2(N);
    localparam int CNT_W = $clog2(N * N + 1);

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, fault_rd_en, chain_start_en, res_valid;
    logic [AW-1:0]    fault_rd_addr, res_row;
    logic [N-1:0]     fault_rd_data = '0;
    logic [N-1:0]     chain_col_inputs, chain_single_pe, chain_col_fault, chain_row_fault;
    logic [N-1:0]     res_pe_mask, sum_col_fault, sum_row_fault;
    logic [CNT_W-1:0] pe_fault_count;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  mem [N];
    logic [N-1:0]  sticky [N];
    logic [AW-1:0] ptr;

    logic [N-1:0]  pm [N];
    logic [AW-1:0] pptr;
    logic [N-1:0]  exp_col, exp_row;

    always #5 clk = ~clk;

    diag_loop_sequencer #(.SYSTOLIC_SIZE(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .fault_rd_en      (fault_rd_en),
        .fault_rd_addr    (fault_rd_addr),
        .fault_rd_data    (fault_rd_data),
        .chain_start_en   (chain_start_en),
        .chain_col_inputs (chain_col_inputs),
        .chain_single_pe  (chain_single_pe),
        .chain_col_fault  (chain_col_fault),
        .chain_row_fault  (chain_row_fault),
        .res_valid        (res_valid),
        .res_row          (res_row),
        .res_pe_mask      (res_pe_mask),
        .sum_col_fault    (sum_col_fault),
        .sum_row_fault    (sum_row_fault),
        .pe_fault_count   (pe_fault_count)
    );

    function automatic void chk(input string tag, input bit ok,
                                input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    always @(posedge clk) begin
        if (fault_rd_en) fault_rd_data <= mem[fault_rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) sticky[i] <= '0;
            ptr <= '0;
        end else if (chain_start_en) begin
            sticky[ptr] <= sticky[ptr] | chain_col_inputs;
            ptr         <= ptr + 1'b1;
        end
    end

    assign chain_single_pe = chain_col_inputs | sticky[ptr];

    always_comb begin
        chain_col_fault = '0;
        chain_row_fault = '0;
        for (int i = 0; i < N; i++) begin
            chain_col_fault    = chain_col_fault | sticky[i];
            chain_row_fault[i] = |sticky[i];
        end
    end

    task automatic clear_model();
        for (int i = 0; i < N; i++) pm[i] = '0;
        pptr    = '0;
        exp_col = '0;
        exp_row = '0;
    endtask

    task automatic check_reset_state();
        chk("rst_busy",      busy === 1'b0,             busy,             0);
        chk("rst_done",      done === 1'b0,             done,             0);
        chk("rst_rd_en",     fault_rd_en === 1'b0,      fault_rd_en,      0);
        chk("rst_rd_addr",   fault_rd_addr === '0,      fault_rd_addr,    0);
        chk("rst_start_en",  chain_start_en === 1'b0,   chain_start_en,   0);
        chk("rst_col_in",    chain_col_inputs === '0,   chain_col_inputs, 0);
        chk("rst_res_valid", res_valid === 1'b0,        res_valid,        0);
        chk("rst_res_row",   res_row === '0,            res_row,          0);
        chk("rst_res_mask",  res_pe_mask === '0,        res_pe_mask,      0);
        chk("rst_sum_col",   sum_col_fault === '0,      sum_col_fault,    0);
        chk("rst_sum_row",   sum_row_fault === '0,      sum_row_fault,    0);
        chk("rst_count",     pe_fault_count === '0,     pe_fault_count,   0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        clear_model();
        @(posedge clk); #1;
    endtask

    task automatic rand_mem();
        for (int r = 0; r < N; r++) mem[r] = N'($urandom & $urandom & $urandom);
    endtask

    task automatic run_pass(input int abort_j, input int extra_j, input bit abort_with_start);
        logic [N-1:0]     emask [N];
        logic [CNT_W-1:0] e_cnt;
        int               ecount;
        int               act_end;
        bit               completed;
        completed = (abort_j == 0);
        act_end   = completed ? 2 * N + 3 : abort_j;
        ecount    = 0;
        for (int i = 0; i < N; i++) emask[i] = '0;
        start = 1'b1;
        abort = abort_with_start;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int j = 1; j <= 2 * N + 4; j++) begin
            logic          e_busy, e_done, e_rd, e_se, e_rv;
            logic [N-1:0]  e_colin;
            logic [AW-1:0] e_addr, e_row;
            e_busy  = (j <= act_end);
            e_done  = completed && (j == 2 * N + 3);
            e_rd    = (j <= N) && (j <= act_end);
            e_se    = (j >= 2) && (j <= 2 * N + 1) && (j <= act_end);
            e_rv    = (j >= 3) && (j <= N + 2) && (j <= act_end + 1);
            e_colin = '0;
            if (e_se && j <= N + 1) e_colin = mem[j - 2];
            chk("busy",     busy === e_busy,               busy,             e_busy);
            chk("done",     done === e_done,               done,             e_done);
            chk("rd_en",    fault_rd_en === e_rd,          fault_rd_en,      e_rd);
            if (e_rd) begin
                e_addr = AW'(j - 1);
                chk("rd_addr", fault_rd_addr === e_addr,   fault_rd_addr,    e_addr);
            end
            chk("start_en", chain_start_en === e_se,       chain_start_en,   e_se);
            chk("col_in",   chain_col_inputs === e_colin,  chain_col_inputs, e_colin);
            chk("res_valid", res_valid === e_rv,           res_valid,        e_rv);
            if (e_rv) begin
                e_row = AW'(j - 3);
                chk("res_row",  res_row === e_row,             res_row,     e_row);
                chk("res_mask", res_pe_mask === emask[j - 3],  res_pe_mask, emask[j - 3]);
                ecount += $countones(emask[j - 3]);
            end
            if (j == 1) begin
                e_cnt = '0;
                chk("count_clr", pe_fault_count === e_cnt, pe_fault_count, e_cnt);
            end
            if (e_se) begin
                if (j <= N + 1) begin
                    emask[j - 2] = mem[j - 2] | pm[pptr];
                    pm[pptr]     = emask[j - 2];
                end
                pptr = pptr + 1'b1;
            end
            abort = (j == abort_j);
            start = (j == extra_j);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
        if (completed) begin
            exp_col = '0;
            for (int r = 0; r < N; r++) begin
                exp_col    = exp_col | pm[r];
                exp_row[r] = |pm[r];
            end
        end
        e_cnt = CNT_W'(ecount);
        chk("count",   pe_fault_count === e_cnt,  pe_fault_count, e_cnt);
        chk("sum_col", sum_col_fault === exp_col, sum_col_fault,  exp_col);
        chk("sum_row", sum_row_fault === exp_row, sum_row_fault,  exp_row);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, e;
        clear_model();
        for (int r = 0; r < N; r++) mem[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        @(posedge clk); #1;

        rand_mem();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (N + 3) @(posedge clk);
        #2;
        chk("sweep_busy",     busy === 1'b1,           busy,           1);
        chk("sweep_start_en", chain_start_en === 1'b1, chain_start_en, 1);
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk) rst_n = 1'b1;
        clear_model();
        @(posedge clk); #1;

        for (int r = 0; r < N; r++) mem[r] = '0;
        run_pass(0, 0, 1'b0);
        mem[3] = 8'b0000_0100;
        run_pass(0, 0, 1'b0);
        run_pass(0, 0, 1'b0);

        do_reset();
        for (int r = 0; r < N; r++) mem[r] = '0;
        mem[2] = 8'hE0;
        mem[3] = 8'hE0;
        mem[4] = 8'hE0;
        run_pass(0, 7, 1'b1);

        run_pass(5, 3, 1'b0);
        rand_mem();
        run_pass(2 * N + 2, 0, 1'b0);
        run_pass(0, 2 * N + 3, 1'b0);

        for (int p = 0; p < 8; p++) begin
            rand_mem();
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * N + 2)) : 0;
            e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (a == 0) ? 2 * N + 3 : a)) : 0;
            run_pass(a, e, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/diag_loop_sequencer.md
# diag_loop_sequencer

Controller that runs one complete diagnostic pass over the systolic-array diagnostic loop chains. It reads the per-row PE fault vectors from the fault-info memory one row per cycle and feeds them into the chain's column inputs. It gates the chain's shift enable, collects the per-row single-PE detections, and captures the final row/column fault summary. It sits between the BIST top FSM (start/done) and the diagnostic loop chain instance.

## Interface
- SYSTOLIC_SIZE, 8, array dimension N (≥3)
- ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row address width
- CNT_WIDTH, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1), PE fault count width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  cancel the pass; sampled in every non-IDLE state
- busy  out  1  high from FEED through DONE
- done  out  1  one-cycle pulse when the summary is valid
- fault_rd_en  out  1  fault memory read strobe
- fault_rd_addr  out  ADDR_WIDTH  row address being read
- fault_rd_data  in  N  row fault vector, valid the cycle after fault_rd_en
- chain_start_en  out  1  shift enable to the loop chain
- chain_col_inputs  out  N  column inputs to the loop chain
- chain_single_pe  in  N  chain single-PE detection (combinational col_0)
- chain_col_fault  in  N  chain column fault detection
- chain_row_fault  in  N  chain row fault detection
- res_valid  out  1  per-row result strobe
- res_row  out  ADDR_WIDTH  row index of res_pe_mask
- res_pe_mask  out  N  registered chain_single_pe for that row
- sum_col_fault  out  N  captured column fault summary
- sum_row_fault  out  N  captured row fault summary
- pe_fault_count  out  CNT_WIDTH  total set bits across all res_pe_mask in the pass

## Operation
- States: IDLE, FEED, SWEEP, CAPTURE, DONE. A counter cnt of width ADDR_WIDTH+1 is cleared on every state entry.
- IDLE: all strobes low. When start=1, go to FEED and clear pe_fault_count.
- FEED lasts N+1 cycles (cnt 0..N).
  - For cnt<N: fault_rd_en=1 and fault_rd_addr=cnt.
  - For cnt≥1: chain_start_en=1 and chain_col_inputs=fault_rd_data.
  - On each such cycle, the next cycle gives res_valid=1, res_row=cnt−1, res_pe_mask=chain_single_pe, and pe_fault_count += popcount(chain_single_pe).
- SWEEP lasts N cycles: chain_start_en=1 and chain_col_inputs=0, so the loop recirculates.
- CAPTURE lasts 1 cycle: chain_start_en=0. sum_col_fault and sum_row_fault are loaded from the chain at the end of this cycle.
- DONE lasts 1 cycle: done=1, then go to IDLE.
- chain_start_en=0 and chain_col_inputs=0 in IDLE, CAPTURE and DONE, so the chain is frozen there.
- abort=1 in any non-IDLE state: go to IDLE next cycle. No done pulse. Summary registers are not updated. Any res_valid already pipelined still completes.
- start while busy is ignored. start and abort high together in IDLE: start wins.
- The chain contents are sticky across passes; only rst_n clears them. A repeated pass therefore reports the accumulated faults.

## Timing
- Reset values: every output is 0; state is IDLE.
- start sampled at edge T:
  - FEED covers cycles T+1..T+N+1.
  - SWEEP covers T+N+2..T+2N+1.
  - CAPTURE is T+2N+2.
  - done=1 during T+2N+3.
  - busy falls at T+2N+4.
- Total latency is 2N+3 cycles (19 for N=8).
- res_valid for row k is high during cycle T+3+k. It is high for exactly N cycles, contiguous.
- sum_* and pe_fault_count hold their values from the done cycle until the next start.
- Read latency of 1 cycle is fixed. No backpressure.

## Structure
- Shared package diag_pkg holds:
  - the state enum diag_state_t
  - the widths derived from SYSTOLIC_SIZE
  - the constants FEED_LEN=N+1 and SWEEP_LEN=N
- Sub-module diag_popcount: N-bit combinational popcount producing a $clog2(N+1)-bit result. It is reused by repair-allocation logic.

## Test plan
All scenarios use N=8.
1. Reset: assert rst_n=0 mid-SWEEP → all outputs 0 and state IDLE asynchronously; a following start runs a normal 19-cycle pass.
2. All-zero memory, start → rd_addr 0..7 on T+1..T+8; res_valid T+3..T+10 with masks 0; done at T+19; sum_*=0; count=0.
3. Row 3 = 8'b0000_0100 and all other rows 0 → res_row=3 mask=0x04; pe_fault_count=1; done at T+19.
4. Rows 2,3,4 = 8'hE0 → pe_fault_count=9; sum_col_fault[7:5] and sum_row_fault match the chain model values at CAPTURE.
5. abort at T+5 → busy low at T+6; no done; sum_* unchanged from the previous pass. start during busy → no effect.
6. Two back-to-back passes without reset on the scenario-3 memory → second pass reports sticky OR'd masks; pe_fault_count is recomputed from 0.
